// File: rtl/clk_div_ratio_detector_if.sv
// clk_div_ratio_detector_if
//   Bundles the observed divided clock and the detector's status outputs.
//   slave  : detector side (samples div_in, drives status).
//   master : observer side (drives div_in, reads status).
// Optional: DIV_ERR_COUNT_EN adds the 8-bit err_cnt status field.
//
// Signals:
//   div_in       divided clock under observation, synchronous to clk
//   ratio        locked divide ratio, 0 when not locked
//   locked       high while the ratio is stable
//   ratio_valid  one-cycle pulse per valid measured period
//   duty_err     one-cycle pulse per odd / out-of-range / non-50% period
//   mismatch     one-cycle pulse when a valid period differs from the lock
//   lost         one-cycle pulse on toggle timeout
//   err_cnt      saturating error event count (DIV_ERR_COUNT_EN only)
interface clk_div_ratio_detector_if #(
    parameter int unsigned RW = 5
);
    logic          div_in;
    logic [RW-1:0] ratio;
    logic          locked;
    logic          ratio_valid;
    logic          duty_err;
    logic          mismatch;
    logic          lost;
`ifdef DIV_ERR_COUNT_EN
    logic [7:0]    err_cnt;

    modport master (
        output div_in,
        input  ratio, locked, ratio_valid, duty_err, mismatch, lost, err_cnt
    );
    modport slave (
        input  div_in,
        output ratio, locked, ratio_valid, duty_err, mismatch, lost, err_cnt
    );
`else
    modport master (
        output div_in,
        input  ratio, locked, ratio_valid, duty_err, mismatch, lost
    );
    modport slave (
        input  div_in,
        output ratio, locked, ratio_valid, duty_err, mismatch, lost
    );
`endif
endinterface

// File: rtl/clk_div_ratio_detector.sv
// clk_div_ratio_detector
//   Monitors one even-divided clock waveform in its source clock domain,
//   measures period and high time in clk cycles, locks onto a stable even
//   ratio and flags duty errors, ratio changes and loss of toggling.
//   All status outputs are registered; a div_in rising edge shows up on the
//   outputs 2 clk later.
//
// Ports:
//   clk     source clock (the observed divider runs from it)
//   resetn  asynchronous active-low reset
//   bus     clk_div_ratio_detector_if.slave (div_in in, status out)
//
// Optional feature macro: DIV_ERR_COUNT_EN
//   Defined: bus.err_cnt counts duty_err/mismatch/lost pulses, saturating
//   at 255, cleared only by resetn.
module clk_div_ratio_detector #(
    parameter int unsigned MAX_RATIO  = 16,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned RW         = $clog2(MAX_RATIO) + 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    clk_div_ratio_detector_if.slave bus
);

    // Counters must hold MAX_RATIO+1 (the timeout/saturation value).
    localparam int unsigned   CW     = $clog2(MAX_RATIO + 2);
    localparam int unsigned   MW     = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] CntSat = CW'(MAX_RATIO + 1);

    typedef enum logic [1:0] {StIdle, StMeasure, StTrack, StLocked} state_e;

    state_e         state_q;
    logic           s_q;
    logic           s_d_q;
    logic [CW-1:0]  per_cnt_q;
    logic [CW-1:0]  hi_cnt_q;
    logic [CW-1:0]  cand_q;
    logic [MW-1:0]  match_q;
    logic [RW-1:0]  ratio_q;
    logic           locked_q;
    logic           rv_q;
    logic           duty_q;
    logic           mism_q;
    logic           lost_q;

    logic           rise;
    logic           timeout;
    logic           period_ok;
    logic [MW-1:0]  match_next;
    logic           lock_hit;

    assign rise    = s_q & ~s_d_q;
    assign timeout = (state_q != StIdle) && (per_cnt_q == CntSat);

    // per_cnt/hi_cnt still hold the just-finished period on the rise cycle.
    assign period_ok = !per_cnt_q[0] &&
                       (per_cnt_q >= CW'(2)) &&
                       (per_cnt_q <= CW'(MAX_RATIO)) &&
                       (hi_cnt_q == (per_cnt_q >> 1));

    assign match_next = match_q + MW'(1);
    assign lock_hit   = 32'(match_next) >= LOCK_COUNT;

    // Input sampling
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_q   <= 1'b0;
            s_d_q <= 1'b0;
        end else begin
            s_q   <= bus.div_in;
            s_d_q <= s_q;
        end
    end

    // Period and high-time counters; both saturate so a stuck input cannot wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
        end else if (rise) begin
            per_cnt_q <= CW'(1);
            hi_cnt_q  <= CW'(s_q);
        end else begin
            if (per_cnt_q != CntSat) begin
                per_cnt_q <= per_cnt_q + CW'(1);
            end
            if (s_q && (hi_cnt_q != CntSat)) begin
                hi_cnt_q <= hi_cnt_q + CW'(1);
            end
        end
    end

    // Lock FSM with registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cand_q   <= '0;
            match_q  <= '0;
            ratio_q  <= '0;
            locked_q <= 1'b0;
            rv_q     <= 1'b0;
            duty_q   <= 1'b0;
            mism_q   <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            rv_q   <= 1'b0;
            duty_q <= 1'b0;
            mism_q <= 1'b0;
            lost_q <= 1'b0;
            if (timeout) begin
                // Wins over a coincident rise; per_cnt stays saturated in IDLE.
                lost_q   <= 1'b1;
                locked_q <= 1'b0;
                ratio_q  <= '0;
                match_q  <= '0;
                state_q  <= StIdle;
            end else if (rise) begin
                unique case (state_q)
                    StIdle: begin
                        // First rise only marks a period start; nothing to evaluate.
                        state_q <= StMeasure;
                    end
                    StMeasure: begin
                        if (period_ok) begin
                            rv_q    <= 1'b1;
                            cand_q  <= per_cnt_q;
                            match_q <= MW'(1);
                            if (LOCK_COUNT == 1) begin
                                locked_q <= 1'b1;
                                ratio_q  <= RW'(per_cnt_q);
                                state_q  <= StLocked;
                            end else begin
                                state_q <= StTrack;
                            end
                        end else begin
                            duty_q <= 1'b1;
                        end
                    end
                    StTrack: begin
                        if (period_ok) begin
                            rv_q <= 1'b1;
                            if (per_cnt_q == cand_q) begin
                                match_q <= match_next;
                                if (lock_hit) begin
                                    locked_q <= 1'b1;
                                    ratio_q  <= RW'(per_cnt_q);
                                    state_q  <= StLocked;
                                end
                            end else begin
                                cand_q  <= per_cnt_q;
                                match_q <= MW'(1);
                            end
                        end else begin
                            duty_q  <= 1'b1;
                            match_q <= '0;
                            state_q <= StMeasure;
                        end
                    end
                    StLocked: begin
                        // cand_q equals the locked ratio while in this state.
                        if (period_ok) begin
                            rv_q <= 1'b1;
                            if (per_cnt_q != cand_q) begin
                                mism_q   <= 1'b1;
                                locked_q <= 1'b0;
                                ratio_q  <= '0;
                                cand_q   <= per_cnt_q;
                                match_q  <= MW'(1);
                                state_q  <= StTrack;
                            end
                        end else begin
                            duty_q   <= 1'b1;
                            locked_q <= 1'b0;
                            ratio_q  <= '0;
                            state_q  <= StMeasure;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.ratio       = ratio_q;
    assign bus.locked      = locked_q;
    assign bus.ratio_valid = rv_q;
    assign bus.duty_err    = duty_q;
    assign bus.mismatch    = mism_q;
    assign bus.lost        = lost_q;

`ifdef DIV_ERR_COUNT_EN
    logic       err_hit;
    logic [7:0] err_cnt_q;

    // Same conditions that set duty_q/mism_q/lost_q, so the count moves with the pulse.
    assign err_hit = timeout ||
                     (rise && (state_q != StIdle) &&
                      (!period_ok || ((state_q == StLocked) && (per_cnt_q != cand_q))));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_cnt_q <= '0;
        end else if (err_hit && (err_cnt_q != 8'hff)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif

endmodule
